// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: drains the UART receive FIFO and turns its byte stream into
// framed packets (SYNC, LEN, payload, XOR checksum). Payload bytes are passed
// straight through from the FIFO read port under valid/ready backpressure.
module rx_frame_ctrl #(
    parameter int                   DATA_SIZE      = 8,
    parameter int                   MAX_LEN        = 16,
    parameter logic [DATA_SIZE-1:0] SYNC_BYTE      = 8'hA5,
    parameter int                   TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic                 busy,
    output logic [15:0]          frame_count
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DATA_SIZE-1:0] MAX_LEN_V = DATA_SIZE'(MAX_LEN);
    localparam logic [DATA_SIZE-1:0] ONE_V     = DATA_SIZE'(1);
    localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_CHK = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK
    } state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] len;
    logic [DATA_SIZE-1:0] chk;
    logic [CNT_W-1:0]     cnt;
    logic [TMO_W-1:0]     tmo_cnt;

    logic at_last;
    logic len_bad;
    logic timeout;

    // The current payload byte is the last one when cnt has reached len-1.
    assign at_last  = (DATA_SIZE'(cnt) == (len - ONE_V));
    assign len_bad  = (fifo_data == '0) || (fifo_data > MAX_LEN_V);
    // Fires on the edge that closes the TIMEOUT_CYCLES-th consecutive empty cycle.
    assign timeout  = (state != HUNT) && fifo_empty && (tmo_cnt == TMO_LAST);
    assign out_data = fifo_data;
    assign busy     = (state != HUNT);

    // Read strobe and payload handshake are combinational in the FIFO word; no pop while empty.
    always_comb begin
        fifo_rd   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            HUNT, LEN, CHK: begin
                fifo_rd = ~fifo_empty;
            end
            PAYLOAD: begin
                out_valid = ~fifo_empty;
                out_last  = ~fifo_empty & at_last;
                fifo_rd   = ~fifo_empty & out_ready;
            end
            default: begin
                fifo_rd = 1'b0;
            end
        endcase
        if (reset) begin
            fifo_rd   = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
        end
    end

    // Frame sequencer: state, length/checksum tracking, timeout and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            len         <= '0;
            chk         <= '0;
            cnt         <= '0;
            tmo_cnt     <= '0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            frame_count <= 16'd0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            // Only an unbroken run of empty cycles inside a frame counts.
            if (state == HUNT || !fifo_empty) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            case (state)
                HUNT: begin
                    if (fifo_rd && fifo_data == SYNC_BYTE) begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (fifo_rd) begin
                        if (len_bad) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            state     <= HUNT;
                        end else begin
                            len   <= fifo_data;
                            chk   <= fifo_data;
                            cnt   <= '0;
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (fifo_rd) begin
                        chk <= chk ^ fifo_data;
                        cnt <= cnt + CNT_W'(1);
                        if (at_last) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (fifo_rd) begin
                        if (fifo_data == chk) begin
                            frame_ok    <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                        end
                        state <= HUNT;
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase

            // A timeout can only occur on an empty cycle, so it never races a pop.
            if (timeout) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TMO;
                state     <= HUNT;
                tmo_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Testbench for rx_frame_ctrl: queue-based FIFO model feeding the DUT, a
// frame-level parser producing expected payload transfers and status events,
// and a per-cycle monitor comparing the DUT against those expectations.
module tb_rx_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;
    logic [15:0] frame_count;

    rx_frame_ctrl #(
        .DATA_SIZE      (8),
        .MAX_LEN        (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd     (fifo_rd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_pass = 0;
    int         cyc = 0;
    logic [7:0] fifo_q[$];
    int         exp_out[$];   // {last, data}
    int         exp_evt[$];   // {frame_count, code}: code 1/2/3 = error, 4 = ok
    int         model_count = 0;
    int         xfer_cyc[$];
    bit         stall_chk = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic void refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endfunction

    // Frame-level reference: walks a byte stream that starts in the hunting state.
    task automatic model_parse(input logic [7:0] b[$]);
        int i;
        int k;
        int n;
        int len;
        logic [7:0] c;
        logic [7:0] d;
        i = 0;
        n = b.size();
        while (i < n) begin
            if (b[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            if (i >= n) break;
            len = b[i];
            i++;
            if (len == 0 || len > 16) begin
                exp_evt.push_back((model_count << 4) | 1);
                continue;
            end
            c = 8'(len);
            for (k = 0; k < len && i < n; k++) begin
                d = b[i];
                i++;
                exp_out.push_back(((k == len - 1) ? 256 : 0) | int'(d));
                c = c ^ d;
            end
            if (k < len || i >= n) break;
            if (b[i] == c) begin
                model_count = (model_count + 1) & 16'hFFFF;
                exp_evt.push_back((model_count << 4) | 4);
            end else begin
                exp_evt.push_back((model_count << 4) | 2);
            end
            i++;
        end
    endtask

    task automatic send(input logic [7:0] b[$]);
        model_parse(b);
        foreach (b[i]) fifo_q.push_back(b[i]);
        refresh_fifo();
    endtask

    // One clock: monitor at the falling edge, update the FIFO model just after the rising edge.
    task automatic tick();
        logic        rd;
        logic [31:0] e;
        logic [3:0]  code;
        @(negedge clk);
        cyc++;
        check_eq("rd_while_empty", {31'b0, fifo_rd & fifo_empty}, 32'd0);
        if (out_valid && out_ready) begin
            e = (exp_out.size() != 0) ? exp_out.pop_front() : 32'hFFFF_FFFF;
            check_eq("xfer", {23'b0, out_last, out_data}, e);
            xfer_cyc.push_back(cyc);
        end
        if (frame_ok || frame_err) begin
            code = (frame_ok && frame_err) ? 4'd7 : (frame_ok ? 4'd4 : {2'b00, err_code});
            e = (exp_evt.size() != 0) ? exp_evt.pop_front() : 32'hFFFF_FFFF;
            $display("cycle %0d: frame event code %0d count %0d", cyc, code, frame_count);
            check_eq("event", {12'b0, frame_count, code}, e);
        end
        if (stall_chk) begin
            check_eq("stall_rd", {31'b0, fifo_rd}, 32'd0);
            check_eq("stall_valid", {31'b0, out_valid}, 32'd1);
            check_eq("stall_data", {24'b0, out_data}, 32'h22);
        end
        rd = fifo_rd;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh_fifo();
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((fifo_q.size() + exp_out.size() + exp_evt.size()) != 0 && k < 1000) begin
            tick();
            k++;
        end
        check_eq({tag, "_drain"}, fifo_q.size() + exp_out.size() + exp_evt.size(), 32'd0);
        repeat (2) tick();
        check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
        exp_out.delete();
        exp_evt.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        check_eq({tag, "_last"}, {31'b0, out_last}, 32'd0);
        check_eq({tag, "_rd"}, {31'b0, fifo_rd}, 32'd0);
        check_eq({tag, "_ok"}, {31'b0, frame_ok}, 32'd0);
        check_eq({tag, "_err"}, {31'b0, frame_err}, 32'd0);
        check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check_eq({tag, "_code"}, {30'b0, err_code}, 32'd0);
        check_eq({tag, "_count"}, {16'b0, frame_count}, 32'd0);
    endtask

    task automatic feed_random(input logic [7:0] b[$]);
        int i;
        int idle;
        model_parse(b);
        i = 0;
        idle = 0;
        while (i < b.size()) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (idle >= 4 || $urandom_range(0, 3) != 0) begin
                fifo_q.push_back(b[i]);
                i++;
                idle = 0;
                refresh_fifo();
            end else begin
                idle++;
            end
            tick();
        end
        out_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] good[$];
        logic [7:0] fr[$];
        logic [7:0] pay;
        logic [7:0] c;
        int k;
        int len;
        bit found;

        good = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};

        // Reset state
        reset = 1'b1;
        refresh_fifo();
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;

        // Good frame, consecutive delivery
        xfer_cyc.delete();
        send(good);
        drain("good");
        check_eq("good_xfers", xfer_cyc.size(), 32'd3);
        if (xfer_cyc.size() == 3) begin
            check_eq("good_gap1", xfer_cyc[1] - xfer_cyc[0], 32'd1);
            check_eq("good_gap2", xfer_cyc[2] - xfer_cyc[1], 32'd1);
        end
        check_eq("good_count", {16'b0, frame_count}, 32'd1);

        // Garbage before sync
        fr = {8'h00, 8'hFF, 8'h5A};
        fr = {fr, good};
        send(fr);
        drain("garbage");
        check_eq("garbage_count", {16'b0, frame_count}, 32'd2);

        // Bad checksum
        fr = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send(fr);
        drain("badchk");
        check_eq("badchk_code", {30'b0, err_code}, 32'd2);
        check_eq("badchk_count", {16'b0, frame_count}, 32'd2);

        // Bad lengths then a good frame
        fr = {8'hA5, 8'h00, 8'hA5, 8'h11};
        fr = {fr, good};
        send(fr);
        drain("badlen");
        check_eq("badlen_count", {16'b0, frame_count}, 32'd3);

        // Backpressure for 5 cycles on byte 22
        send(good);
        found = 1'b0;
        k = 0;
        while (!found && k < 50) begin
            tick();
            k++;
            if (out_valid && out_data == 8'h22) found = 1'b1;
        end
        check_eq("bp_reach", {31'b0, found}, 32'd1);
        out_ready = 1'b0;
        stall_chk = 1'b1;
        repeat (5) tick();
        stall_chk = 1'b0;
        out_ready = 1'b1;
        drain("bp");
        check_eq("bp_count", {16'b0, frame_count}, 32'd4);

        // Timeout after 20 empty cycles mid-payload
        fr = {8'hA5, 8'h04, 8'h11};
        send(fr);
        k = 0;
        while (fifo_q.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        repeat (20) tick();
        exp_evt.push_back((model_count << 4) | 3);
        tick();
        check_eq("tmo_pulse_cycle", exp_evt.size(), 32'd0);
        check_eq("tmo_code", {30'b0, err_code}, 32'd3);
        exp_evt.delete();
        drain("tmo");

        // Reset mid-payload
        fr = {8'hA5, 8'h04, 8'h11, 8'h22};
        send(fr);
        k = 0;
        while (fifo_q.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        repeat (2) tick();
        check_eq("pre_rst_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) tick();
        reset = 1'b0;
        check_eq("midrst_pending", exp_out.size() + exp_evt.size(), 32'd0);
        exp_out.delete();
        exp_evt.delete();
        model_count = 0;
        send(good);
        drain("postrst");
        check_eq("postrst_count", {16'b0, frame_count}, 32'd1);

        // Randomized frame mix with random gaps and backpressure
        fr.delete();
        for (int f = 0; f < 14; f++) begin
            case ($urandom_range(0, 3))
                0, 1, 3: begin
                    if (f % 3 == 0) begin
                        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                            pay = 8'($urandom_range(0, 255));
                            if (pay == 8'hA5) pay = 8'h5A;
                            fr.push_back(pay);
                        end
                    end
                    len = $urandom_range(1, 16);
                    fr.push_back(8'hA5);
                    fr.push_back(8'(len));
                    c = 8'(len);
                    for (int p = 0; p < len; p++) begin
                        pay = 8'($urandom_range(0, 255));
                        fr.push_back(pay);
                        c = c ^ pay;
                    end
                    if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
                    fr.push_back(c);
                end
                default: begin
                    fr.push_back(8'hA5);
                    fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
                end
            endcase
        end
        feed_random(fr);
        drain("random");
        check_eq("random_count", {16'b0, frame_count}, 32'(model_count));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
